multicycle_control: RTL

- Main control FSM for the multicycle CPU datapath.
- Decodes opcode/funct and sequences FETCH → DECODE → execute states.
- Drives the ALU select/operation inputs (`alu_src_A`, `alu_src_B`, `alu_control`) and all datapath write enables.
- Consumes the ALU `zero` flag to resolve `beq`. This is the driving end of the ALU control interface.

---
 rtl/multicycle_control.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle CPU datapath.
// Sequences FETCH/DECODE/execute states and drives ALU selects and write enables.
module multicycle_control #(
  parameter int          STATE_W  = 4,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_J     = 6'b000010,
  parameter logic [5:0]  OP_ADDI  = 6'b001000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic [3:0]         alu_control,
  output logic               alu_src_A,
  output logic [1:0]         alu_src_B,
  output logic               pc_en,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = STATE_W'(0),
    S_DECODE    = STATE_W'(1),
    S_MEMADDR   = STATE_W'(2),
    S_MEMREAD   = STATE_W'(3),
    S_MEMWB     = STATE_W'(4),
    S_MEMWRITE  = STATE_W'(5),
    S_EXEC_R    = STATE_W'(6),
    S_RTYPE_WB  = STATE_W'(7),
    S_BRANCH    = STATE_W'(8),
    S_JUMP      = STATE_W'(9),
    S_ADDI_EXEC = STATE_W'(10),
    S_ADDI_WB   = STATE_W'(11)
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1001;

  state_t state_q;
  state_t state_d;

  logic       funct_ok;
  logic [3:0] r_alu;
  logic       op_ok;
  logic       is_illegal;

  logic pc_write;
  logic branch_state;
  logic ir_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;

  // Map R-type funct to an ALU code; unknown functs fall back to add.
  always_comb begin
    funct_ok = 1'b1;
    r_alu    = ALU_ADD;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100111: r_alu = ALU_NOR;
      6'b000000: r_alu = ALU_SLL;
      default:   funct_ok = 1'b0;
    endcase
  end

  assign op_ok = (opcode == OP_RTYPE) || (opcode == OP_LW) ||
                 (opcode == OP_SW) || (opcode == OP_BEQ) ||
                 (opcode == OP_J) || (opcode == OP_ADDI);

  assign is_illegal = !op_ok ||
                      ((opcode == OP_RTYPE) && !funct_ok);

  // Next-state selection; stray encodings recover to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):     state_d = S_MEMADDR;
          (opcode == OP_RTYPE):  state_d = S_EXEC_R;
          (opcode == OP_BEQ):    state_d = S_BRANCH;
          (opcode == OP_J):      state_d = S_JUMP;
          (opcode == OP_ADDI):   state_d = S_ADDI_EXEC;
          default:               state_d = S_FETCH;
        endcase
      end
      S_MEMADDR:
        state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:   state_d = S_MEMWB;
      S_EXEC_R:    state_d = S_RTYPE_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  // State register; reset snaps straight back to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Moore decode of datapath controls from the current state.
  always_comb begin
    alu_control   = ALU_ADD;
    alu_src_A     = 1'b0;
    alu_src_B     = 2'b00;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;
    pc_write      = 1'b0;
    branch_state  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read     = 1'b1;
        ir_write_raw = 1'b1;
        alu_src_B    = 2'b01;
        pc_write     = 1'b1;
      end
      S_DECODE: begin
        alu_src_B  = 2'b10;
        illegal_op = is_illegal;
      end
      S_MEMADDR: begin
        alu_src_A = 1'b1;
        alu_src_B = 2'b10;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write_raw = 1'b1;
        i_or_d        = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_A   = 1'b1;
        alu_control = r_alu;
      end
      S_RTYPE_WB: begin
        reg_write_raw = funct_ok;
        reg_dst       = 1'b1;
      end
      S_BRANCH: begin
        alu_src_A    = 1'b1;
        alu_control  = ALU_SUB;
        pc_source    = 2'b01;
        branch_state = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_A = 1'b1;
        alu_src_B = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural writes are suppressed while reset is held.
  assign pc_en     = !reset & (pc_write | (branch_state & zero));
  assign ir_write  = !reset & ir_write_raw;
  assign mem_write = !reset & mem_write_raw;
  assign reg_write = !reset & reg_write_raw;
  assign state     = state_q;

endmodule
